// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath word width and word type.
package alu_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

endpackage : alu_pkg

// File: rtl/full_adder_1.sv
// One-bit full-adder cell; chained to form the ripple-carry datapath.
module full_adder_1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and majority-carry of the three input bits.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule : full_adder_1

// File: rtl/full_adder16.sv
// Ripple-carry adder with one registered output stage. Exposes the full per-bit
// carry vector so callers can derive flags (e.g. signed overflow) without re-adding.
module full_adder16
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] add_in1,
  input  logic [WIDTH-1:0] add_in2,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout,
  output logic             out_valid
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the final carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] cout_d;

  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] cout_q;
  logic             out_valid_q;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_1 u_cell (
      .a  (add_in1[i]),
      .b  (add_in2[i]),
      .ci (carry[i]),
      .s  (sum_d[i]),
      .co (carry[i+1])
    );
  end

  // Carry-out vector: cout[i] is the carry leaving bit i.
  always_comb begin
    cout_d = carry[WIDTH:1];
  end

  // Output register: captures only on accepted operations so held results
  // are immune to garbage on the operand inputs while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule : full_adder16

// File: tb/tb_full_adder16.sv
// Self-checking bench for full_adder16 using an expected-result queue.
module tb_full_adder16;
  import alu_pkg::*;

  typedef struct packed {
    word_t s;
    word_t c;
  } exp_t;

  logic  clk;
  logic  rst;
  word_t add_in1;
  word_t add_in2;
  logic  cin;
  logic  in_valid;
  word_t sum;
  word_t cout;
  logic  out_valid;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  full_adder16 #(.WIDTH(WORD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .add_in1   (add_in1),
    .add_in2   (add_in2),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: carry out of bit i from the exact sum of the low i+1 bits.
  function automatic exp_t model(input word_t a, input word_t b, input logic c);
    exp_t        e;
    logic [16:0] full;
    logic [16:0] part;
    logic [16:0] mask;
    full = {1'b0, a} + {1'b0, b} + {16'd0, c};
    e.s  = full[15:0];
    for (int i = 0; i < 16; i++) begin
      mask   = (17'd1 << (i + 1)) - 17'd1;
      part   = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'd0, c};
      e.c[i] = part[i+1];
    end
    return e;
  endfunction

  // Drive one cycle of stimulus at the falling edge, record expectation,
  // then return just after the capturing rising edge.
  task automatic drive(input word_t a, input word_t b, input logic c, input logic v);
    @(negedge clk);
    add_in1  = a;
    add_in2  = b;
    cin      = c;
    in_valid = v;
    if (v) exp_q.push_back(model(a, b, c));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (sum !== 16'h0 || cout !== 16'h0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state sum=%h cout=%h ov=%b required 0000 0000 0", sum, cout, out_valid);
    end
  endtask

  task automatic test_directed();
    exp_t  e;
    word_t ta[5] = '{16'd514, 16'hFFFF, 16'h5555, 16'h5555, 16'h1234};
    word_t tb[5] = '{16'd2,   16'h0001, 16'hAAAA, 16'hAAAA, 16'h0FED};
    logic  tc[5] = '{1'b0,    1'b0,     1'b1,     1'b0,     1'b1};
    word_t rs[5] = '{16'd516, 16'h0000, 16'h0000, 16'hFFFF, 16'h2222};
    word_t rc[5] = '{16'h0002, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h1FFD};
    for (int i = 0; i < 5; i++) begin
      drive(ta[i], tb[i], tc[i], 1'b1);
      e = exp_q.pop_front();
      n_checks++;
      if (sum !== rs[i] || cout !== rc[i] || out_valid !== 1'b1 || e.s !== rs[i]
          || e.c !== rc[i]) begin
        n_fail++;
        $display("FAIL directed_%0d sum=%h cout=%h ov=%b required %h %h 1 (model %h %h)",
                 i, sum, cout, out_valid, rs[i], rc[i], e.s, e.c);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drive(16'd3, 16'd4, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_checks++;
    if (sum !== 16'd7 || cout !== 16'h0000 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first sum=%h cout=%h ov=%b required 0007 0000 1", sum, cout, out_valid);
    end
    drive(16'h8000, 16'h8000, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_checks++;
    if (sum !== 16'h0000 || cout !== 16'h8000 || out_valid !== 1'b1 || e.c !== 16'h8000) begin
      n_fail++;
      $display("FAIL b2b_second sum=%h cout=%h ov=%b required 0000 8000 1", sum, cout, out_valid);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    drive(16'h00FF, 16'h0F0F, 1'b1, 1'b1);
    e = exp_q.pop_front();
    n_checks++;
    if (sum !== e.s || cout !== e.c) begin
      n_fail++;
      $display("FAIL pre_reset sum=%h cout=%h required %h %h", sum, cout, e.s, e.c);
    end
    // Set up a valid op, then reset between edges before it is captured.
    @(negedge clk);
    add_in1  = 16'h1111;
    add_in2  = 16'h2222;
    cin      = 1'b0;
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (sum !== 16'h0 || cout !== 16'h0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset sum=%h cout=%h ov=%b required 0000 0000 0", sum, cout, out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (sum !== 16'h0 || cout !== 16'h0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold sum=%h cout=%h ov=%b required 0000 0000 0", sum, cout, out_valid);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    drive(16'h1111, 16'h2222, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_checks++;
    if (sum !== 16'h3333 || cout !== 16'h0000 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset sum=%h cout=%h ov=%b required 3333 0000 1", sum, cout, out_valid);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    drive(16'hF00F, 16'h0FF1, 1'b0, 1'b1);
    e = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive(word_t'($urandom), (i == 0) ? 16'hxxxx : word_t'($urandom), i[0], 1'b0);
      n_checks++;
      if (sum !== e.s || cout !== e.c || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d sum=%h cout=%h ov=%b required %h %h 0",
                 i, sum, cout, out_valid, e.s, e.c);
      end
    end
  endtask

  task automatic test_random();
    exp_t  e;
    word_t a;
    word_t b;
    logic  c;
    for (int i = 0; i < 10000; i++) begin
      a = word_t'($urandom);
      b = word_t'($urandom);
      c = 1'($urandom);
      drive(a, b, c, 1'b1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL random_queue_empty at %0d", i);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (sum !== e.s || cout !== e.c || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL random_%0d a=%h b=%h c=%b sum=%h cout=%h ov=%b required %h %h 1",
                   i, a, b, c, sum, cout, out_valid, e.s, e.c);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    add_in1  = '0;
    add_in2  = '0;
    cin      = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_directed();
    test_back_to_back();
    test_async_reset();
    test_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_full_adder16
